class_score_argmax_ctrl: RTL

//  Sequential argmax controller for the classifier output score RAM.
//  On start it drives read port B of the output dual-port RAM and scans NUM_CLASS

---
 rtl/class_score_argmax_ctrl_if.sv | 39 +++
 rtl/class_score_argmax_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/class_score_argmax_ctrl_if.sv
// ----------------------------------------------------------------------------
// class_score_argmax_ctrl_if
//   Read port B of the classifier output score RAM, as seen by the argmax
//   controller.
//
//   Signals
//     ram_enb    port B enable (controller -> RAM)
//     ram_web    port B write enable, the controller always drives 0
//     ram_addrb  port B address (AWIDTH bits)
//     ram_doutb  port B read data (DWIDTH bits), registered one cycle after
//                the enable/address that requested it
//
//   Modports
//     master  the controller that issues the reads
//     slave   the RAM port that returns the data
// ----------------------------------------------------------------------------
interface class_score_argmax_ctrl_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              ram_enb;
    logic              ram_web;
    logic [AWIDTH-1:0] ram_addrb;
    logic [DWIDTH-1:0] ram_doutb;

    modport master (
        output ram_enb,
        output ram_web,
        output ram_addrb,
        input  ram_doutb
    );

    modport slave (
        input  ram_enb,
        input  ram_web,
        input  ram_addrb,
        output ram_doutb
    );
endinterface

// File: rtl/class_score_argmax_ctrl.sv
// ----------------------------------------------------------------------------
// class_score_argmax_ctrl
//   Sequential argmax over NUM_CLASS consecutive signed scores held in the
//   classifier output RAM, starting at BASE_ADDR. One address is issued and
//   one score is compared per cycle. On ties the lowest index wins.
//
//   Ports
//     clk        clock, all logic on posedge
//     rst_n      asynchronous active-low reset
//     start      scan request, sampled only while busy==0
//     busy       high from the cycle after start is accepted until done
//     done       one-cycle pulse, label_out/max_val updated on that edge
//     ram        RAM port B (master modport): enable, write enable, address,
//                read data with one cycle of registered latency
//     label_out  index of the winning score (0..NUM_CLASS-1)
//     max_val    winning score
//     valid      label_out/max_val hold a completed result
//     state_dbg  current FSM state (IDLE=0, SCAN=1, DRAIN=2)
//
//   Handshake: start is a request that is accepted on any rising edge where
//   busy==0 (including the done cycle, which gives back-to-back scans). A
//   request while busy==1 is dropped, not queued. done is the completion
//   strobe; valid stays high from done until the next accepted start.
// ----------------------------------------------------------------------------
module class_score_argmax_ctrl #(
    parameter int AWIDTH    = 10,
    parameter int DWIDTH    = 32,
    parameter int NUM_CLASS = 5,
    parameter int BASE_ADDR = 0,
    parameter int LABEL_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    class_score_argmax_ctrl_if.master ram,
    output logic [LABEL_W-1:0]   label_out,
    output logic [DWIDTH-1:0]    max_val,
    output logic                 valid,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [AWIDTH-1:0]  BASE_A   = AWIDTH'(BASE_ADDR);
    localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_CLASS - 1);
    localparam logic [LABEL_W-1:0] IDX_ONE  = LABEL_W'(1);

    logic [1:0]         state;
    logic [LABEL_W-1:0] rd_idx;     // index of the address currently issued
    logic [LABEL_W-1:0] cmp_idx;    // index of the word currently on ram_doutb
    logic               cmp_valid;  // ram_doutb holds a requested word
    logic               cmp_first;  // next qualified word is class 0
    logic [DWIDTH-1:0]  cand_val;
    logic [LABEL_W-1:0] cand_idx;

    logic               take_word;
    logic [DWIDTH-1:0]  nxt_val;
    logic [LABEL_W-1:0] nxt_idx;
    logic [LABEL_W-1:0] rd_nxt;

    assign state_dbg = state;
    assign rd_nxt    = rd_idx + IDX_ONE;

    // Candidate update. Strict greater-than keeps the earliest index on ties.
    // The DRAIN edge loads the outputs from nxt_* so the last word is
    // included without an extra cycle.
    always_comb begin
        take_word = 1'b0;
        if (cmp_valid) begin
            take_word = cmp_first || ($signed(ram.ram_doutb) > $signed(cand_val));
        end
        nxt_val = take_word ? ram.ram_doutb : cand_val;
        nxt_idx = take_word ? cmp_idx       : cand_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            label_out     <= '0;
            max_val       <= '0;
            ram.ram_enb   <= 1'b0;
            ram.ram_web   <= 1'b0;
            ram.ram_addrb <= '0;
            rd_idx        <= '0;
            cmp_idx       <= '0;
            cmp_valid     <= 1'b0;
            cmp_first     <= 1'b0;
            cand_val      <= '0;
            cand_idx      <= '0;
        end else begin
            done        <= 1'b0;
            ram.ram_web <= 1'b0;
            // Read data follows the enable by one cycle.
            cmp_valid   <= ram.ram_enb;

            if (cmp_valid) begin
                cand_val  <= nxt_val;
                cand_idx  <= nxt_idx;
                cmp_idx   <= cmp_idx + IDX_ONE;
                cmp_first <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_SCAN;
                        busy          <= 1'b1;
                        valid         <= 1'b0;
                        ram.ram_enb   <= 1'b1;
                        ram.ram_addrb <= BASE_A;
                        rd_idx        <= '0;
                        cmp_idx       <= '0;
                        cmp_first     <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (rd_idx == LAST_IDX) begin
                        state       <= ST_DRAIN;
                        ram.ram_enb <= 1'b0;
                    end else begin
                        rd_idx        <= rd_nxt;
                        ram.ram_addrb <= BASE_A + AWIDTH'(rd_nxt);
                    end
                end

                ST_DRAIN: begin
                    // The last word is on ram_doutb this cycle.
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    valid     <= 1'b1;
                    label_out <= nxt_idx;
                    max_val   <= nxt_val;
                end

                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    ram.ram_enb <= 1'b0;
                end
            endcase
        end
    end

endmodule
